prach_ant_tdm: RTL and testbench

// Input stage of the PRACH chain: takes one parallel sample per antenna per carrier on a

---
 rtl/prach_ant_tdm_if.sv | 32 +++
 rtl/prach_ant_tdm.sv | 144 ++++++++++++++
 tb/tb_prach_ant_tdm.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/prach_ant_tdm_if.sv
// Sample bus of the PRACH antenna TDM stage: parallel antenna/carrier input side and
// serialized antenna-interleaved output side.
interface prach_ant_tdm_if #(
  parameter int NUM_CC  = 3,
  parameter int NUM_ANT = 8,
  parameter int DW      = 16
);
  localparam int CW = $clog2(NUM_ANT);

  // Strobe semantics, no back-pressure: a sample transfers on every clock where din_valid is 1
  // (sync_in qualifies it only then); dout_* carries one antenna slot on every clock where
  // dout_valid is 1, and the consumer must take it.
  logic [NUM_CC-1:0][NUM_ANT-1:0][DW-1:0] din_dr;
  logic [NUM_CC-1:0][NUM_ANT-1:0][DW-1:0] din_di;
  logic                                   din_valid;
  logic                                   sync_in;
  logic [NUM_CC-1:0][DW-1:0]              dout_dr;
  logic [NUM_CC-1:0][DW-1:0]              dout_di;
  logic [CW-1:0]                          dout_chn;
  logic                                   dout_valid;
  logic                                   sync_out;

  modport master (
    output din_dr, din_di, din_valid, sync_in,
    input  dout_dr, dout_di, dout_chn, dout_valid, sync_out
  );

  modport slave (
    input  din_dr, din_di, din_valid, sync_in,
    output dout_dr, dout_di, dout_chn, dout_valid, sync_out
  );
endinterface

// File: rtl/prach_ant_tdm.sv
// PRACH input stage: serializes one parallel multi-antenna sample per strobe into an
// antenna-interleaved TDM stream, with a SHIFT/HOLD bank pair absorbing strobe jitter.
module prach_ant_tdm #(
  parameter int NUM_CC  = 3,
  parameter int NUM_ANT = 8,
  parameter int DW      = 16
) (
  input  logic          clk_dsp,
  input  logic          rst_dsp_n,
  prach_ant_tdm_if.slave bus,
  input  logic          stat_clr,
  output logic          ovf_flag,
  output logic          sync_err,
  output logic [15:0]   drop_cnt,
  output logic          dbg_state
);
  localparam int CW = $clog2(NUM_ANT);

  typedef enum logic {S_IDLE = 1'b0, S_EMIT = 1'b1} state_t;

  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  logic [NUM_CC-1:0][NUM_ANT-1:0][DW-1:0] shift_dr, shift_di, hold_dr, hold_di;
  logic shift_sync, hold_sync, hold_v;

  logic shift_from_din, shift_from_hold, hold_from_din, hold_clr, drop;
  logic last;

  assign last      = (cnt == CW'(NUM_ANT - 1));
  assign dbg_state = (state == S_EMIT);

  always_ff @(posedge clk_dsp or negedge rst_dsp_n) begin
    if (!rst_dsp_n) state <= S_IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx        = state;
    cnt_nx          = cnt;
    shift_from_din  = 1'b0;
    shift_from_hold = 1'b0;
    hold_from_din   = 1'b0;
    hold_clr        = 1'b0;
    drop            = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.din_valid) begin
          shift_from_din = 1'b1;
          state_nx       = S_EMIT;
          cnt_nx         = '0;
        end
      end
      S_EMIT: begin
        if (last) begin
          cnt_nx = '0;
          // On the last slot a waiting HOLD sample always advances, so a new strobe fits.
          if (hold_v) begin
            shift_from_hold = 1'b1;
            if (bus.din_valid) hold_from_din = 1'b1;
            else               hold_clr      = 1'b1;
          end else if (bus.din_valid) begin
            shift_from_din = 1'b1;
          end else begin
            state_nx = S_IDLE;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
          if (bus.din_valid) begin
            if (hold_v) drop          = 1'b1;
            else        hold_from_din = 1'b1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_dsp or negedge rst_dsp_n) begin
    if (!rst_dsp_n) begin
      cnt        <= '0;
      shift_dr   <= '0;
      shift_di   <= '0;
      shift_sync <= 1'b0;
      hold_dr    <= '0;
      hold_di    <= '0;
      hold_sync  <= 1'b0;
      hold_v     <= 1'b0;
    end else begin
      cnt <= cnt_nx;
      if (shift_from_din) begin
        shift_dr   <= bus.din_dr;
        shift_di   <= bus.din_di;
        shift_sync <= bus.sync_in;
      end else if (shift_from_hold) begin
        shift_dr   <= hold_dr;
        shift_di   <= hold_di;
        shift_sync <= hold_sync;
      end
      if (hold_from_din) begin
        hold_dr   <= bus.din_dr;
        hold_di   <= bus.din_di;
        hold_sync <= bus.sync_in;
        hold_v    <= 1'b1;
      end else if (hold_clr) begin
        hold_v <= 1'b0;
      end
    end
  end

  // Outputs are a pure mux of registered state, so chn 0 appears the cycle after the strobe.
  always_comb begin
    bus.dout_valid = (state == S_EMIT);
    bus.dout_chn   = (state == S_EMIT) ? cnt : '0;
    bus.sync_out   = (state == S_EMIT) && shift_sync && (cnt == '0);
    bus.dout_dr    = '0;
    bus.dout_di    = '0;
    if (state == S_EMIT) begin
      for (int cc = 0; cc < NUM_CC; cc++) begin
        bus.dout_dr[cc] = shift_dr[cc][cnt];
        bus.dout_di[cc] = shift_di[cc][cnt];
      end
    end
  end

  // A clear in the same cycle as a new event wins; that event is lost.
  always_ff @(posedge clk_dsp or negedge rst_dsp_n) begin
    if (!rst_dsp_n) begin
      ovf_flag <= 1'b0;
      sync_err <= 1'b0;
      drop_cnt <= '0;
    end else if (stat_clr) begin
      ovf_flag <= 1'b0;
      sync_err <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (drop) begin
        ovf_flag <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
      if (bus.sync_in && !bus.din_valid) sync_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_prach_ant_tdm.sv
// Bench for prach_ant_tdm: queue-of-beats reference model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_prach_ant_tdm;
  localparam int NUM_CC  = 3;
  localparam int NUM_ANT = 8;
  localparam int DW      = 16;
  localparam int CW      = $clog2(NUM_ANT);

  typedef struct packed {
    logic [NUM_CC-1:0][DW-1:0] dr;
    logic [NUM_CC-1:0][DW-1:0] di;
    logic [CW-1:0]             chn;
    logic                      sync;
  } beat_t;

  logic        clk_dsp = 1'b0;
  logic        rst_dsp_n = 1'b0;
  logic        stat_clr = 1'b0;
  logic        ovf_flag, sync_err, dbg_state;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  prach_ant_tdm_if #(.NUM_CC(NUM_CC), .NUM_ANT(NUM_ANT), .DW(DW)) bus ();

  prach_ant_tdm #(.NUM_CC(NUM_CC), .NUM_ANT(NUM_ANT), .DW(DW)) dut (
    .clk_dsp  (clk_dsp),
    .rst_dsp_n(rst_dsp_n),
    .bus      (bus),
    .stat_clr (stat_clr),
    .ovf_flag (ovf_flag),
    .sync_err (sync_err),
    .drop_cnt (drop_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk_dsp = ~clk_dsp;

  // ---------------- reference model + per-cycle compare ----------------
  // Every accepted strobe appends NUM_ANT beats; one beat leaves per clock. A strobe is
  // accepted iff no more than NUM_ANT beats are still queued after the current one.
  beat_t       exp_q[$];
  logic        m_ovf = 1'b0;
  logic        m_serr = 1'b0;
  logic [15:0] m_drop = '0;

  always @(negedge clk_dsp) begin
    beat_t e;
    logic  ev;
    beat_t nb;
    logic  drop_ev;
    e  = '0;
    ev = 1'b0;
    if (!rst_dsp_n) begin
      exp_q.delete();
      m_ovf  = 1'b0;
      m_serr = 1'b0;
      m_drop = '0;
    end else if (exp_q.size() > 0) begin
      e  = exp_q[0];
      ev = 1'b1;
    end
    checks++;
    if (bus.dout_valid !== ev || bus.dout_chn !== e.chn || bus.dout_dr !== e.dr ||
        bus.dout_di !== e.di || bus.sync_out !== e.sync || ovf_flag !== m_ovf ||
        sync_err !== m_serr || drop_cnt !== m_drop) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t got v=%b chn=%0d dr=%h di=%h sync=%b ovf=%b serr=%b drop=%h | exp v=%b chn=%0d dr=%h di=%h sync=%b ovf=%b serr=%b drop=%h",
               $time, bus.dout_valid, bus.dout_chn, bus.dout_dr, bus.dout_di, bus.sync_out,
               ovf_flag, sync_err, drop_cnt, ev, e.chn, e.dr, e.di, e.sync, m_ovf, m_serr, m_drop);
    end
    if (rst_dsp_n) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      drop_ev = 1'b0;
      if (bus.din_valid) begin
        if (exp_q.size() <= NUM_ANT) begin
          for (int a = 0; a < NUM_ANT; a++) begin
            nb = '0;
            for (int cc = 0; cc < NUM_CC; cc++) begin
              nb.dr[cc] = bus.din_dr[cc][a];
              nb.di[cc] = bus.din_di[cc][a];
            end
            nb.chn  = CW'(a);
            nb.sync = bus.sync_in && (a == 0);
            exp_q.push_back(nb);
          end
        end else begin
          drop_ev = 1'b1;
        end
      end
      if (stat_clr) begin
        m_ovf  = 1'b0;
        m_serr = 1'b0;
        m_drop = '0;
      end else begin
        if (drop_ev) begin
          m_ovf = 1'b1;
          if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end
        if (bus.sync_in && !bus.din_valid) m_serr = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_sample(input logic [15:0] base);
    for (int cc = 0; cc < NUM_CC; cc++)
      for (int a = 0; a < NUM_ANT; a++) begin
        bus.din_dr[cc][a] = base + 16'(16 * cc + a);
        bus.din_di[cc][a] = (base + 16'(16 * cc + a)) ^ 16'hA5A5;
      end
  endtask

  // Drives one clock of inputs, returns #1 after the edge that samples them.
  task automatic drive_cycle(input logic v, input logic s, input logic [15:0] base);
    bus.din_valid = v;
    bus.sync_in   = s;
    if (v) set_sample(base);
    @(posedge clk_dsp);
    #1;
  endtask

  task automatic pulse_clr();
    stat_clr = 1'b1;
    drive_cycle(1'b0, 1'b0, 16'h0);
    stat_clr = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int vcnt;
    bus.din_dr    = '0;
    bus.din_di    = '0;
    bus.din_valid = 1'b0;
    bus.sync_in   = 1'b0;
    repeat (3) @(posedge clk_dsp);
    #1;
    chk("reset_valid", 32'(bus.dout_valid), 32'h0);
    chk("reset_drop", 32'(drop_cnt), 32'h0);
    rst_dsp_n = 1'b1;
    repeat (3) drive_cycle(1'b0, 1'b0, 16'h0);

    // 1: single synced strobe, chn 0..7 with 1-cycle latency
    drive_cycle(1'b1, 1'b1, 16'h1000);
    for (int k = 0; k < NUM_ANT; k++) begin
      chk("t1_valid", 32'(bus.dout_valid), 32'h1);
      chk("t1_chn", 32'(bus.dout_chn), 32'(k));
      chk("t1_dr1", 32'(bus.dout_dr[1]), 32'(16'h1010 + k));
      chk("t1_sync", 32'(bus.sync_out), (k == 0) ? 32'h1 : 32'h0);
      drive_cycle(1'b0, 1'b0, 16'h0);
    end
    chk("t1_end_valid", 32'(bus.dout_valid), 32'h0);
    chk("t1_end_dr", 32'(bus.dout_dr[1]), 32'h0);

    // 2: nominal strobe rate, 100 samples, output never gaps
    vcnt = 0;
    for (int s = 0; s < 100; s++) begin
      drive_cycle(1'b1, 1'b0, 16'(s * 256));
      vcnt += int'(bus.dout_valid);
      for (int i = 0; i < NUM_ANT - 1; i++) begin
        drive_cycle(1'b0, 1'b0, 16'h0);
        vcnt += int'(bus.dout_valid);
      end
    end
    chk("t2_valid_cycles", 32'(vcnt), 32'd800);
    repeat (4) drive_cycle(1'b0, 1'b0, 16'h0);
    chk("t2_ovf", 32'(ovf_flag), 32'h0);
    chk("t2_drop", 32'(drop_cnt), 32'h0);

    // 3: strobes at 0,3,5 -> third dropped, two samples back-to-back
    vcnt = 0;
    for (int i = 0; i < 24; i++) begin
      drive_cycle((i == 0 || i == 3 || i == 5), 1'b0, 16'(16'h3000 + 16'(i) * 16'h100));
      vcnt += int'(bus.dout_valid);
    end
    chk("t3_valid_cycles", 32'(vcnt), 32'd16);
    chk("t3_ovf", 32'(ovf_flag), 32'h1);
    chk("t3_drop", 32'(drop_cnt), 32'h1);
    pulse_clr();
    chk("t3_clr_ovf", 32'(ovf_flag), 32'h0);
    chk("t3_clr_drop", 32'(drop_cnt), 32'h0);

    // 4: strobe on last emit cycle with HOLD full -> no drop, 24 contiguous cycles
    vcnt = 0;
    for (int i = 0; i < 32; i++) begin
      drive_cycle((i == 0 || i == 3 || i == 8), 1'b0, 16'(16'h4000 + 16'(i) * 16'h100));
      vcnt += int'(bus.dout_valid);
    end
    chk("t4_valid_cycles", 32'(vcnt), 32'd24);
    chk("t4_ovf", 32'(ovf_flag), 32'h0);

    // 5: orphan sync
    drive_cycle(1'b0, 1'b1, 16'h0);
    chk("t5_sync_err", 32'(sync_err), 32'h1);
    chk("t5_sync_out", 32'(bus.sync_out), 32'h0);
    chk("t5_valid", 32'(bus.dout_valid), 32'h0);
    drive_cycle(1'b0, 1'b0, 16'h0);
    pulse_clr();
    chk("t5_clr", 32'(sync_err), 32'h0);

    // 6: reset mid-emission, then clean restart
    drive_cycle(1'b1, 1'b1, 16'h6000);
    repeat (3) drive_cycle(1'b0, 1'b0, 16'h0);
    chk("t6_chn3", 32'(bus.dout_chn), 32'd3);
    rst_dsp_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bus.dout_valid), 32'h0);
    chk("t6_rst_chn", 32'(bus.dout_chn), 32'h0);
    chk("t6_rst_dr0", 32'(bus.dout_dr[0]), 32'h0);
    chk("t6_rst_sync", 32'(bus.sync_out), 32'h0);
    @(posedge clk_dsp);
    #1;
    rst_dsp_n = 1'b1;
    drive_cycle(1'b0, 1'b0, 16'h0);
    chk("t6_after_valid", 32'(bus.dout_valid), 32'h0);
    chk("t6_after_drop", 32'(drop_cnt), 32'h0);
    drive_cycle(1'b1, 1'b0, 16'h6100);
    chk("t6_restart_chn", 32'(bus.dout_chn), 32'h0);
    chk("t6_restart_dr2", 32'(bus.dout_dr[2]), 32'h6120);
    repeat (10) drive_cycle(1'b0, 1'b0, 16'h0);

    // drop counter saturation: strobe every cycle drops 7 of every 8
    for (int i = 0; i < 75000; i++) drive_cycle(1'b1, 1'b0, 16'(i));
    repeat (20) drive_cycle(1'b0, 1'b0, 16'h0);
    chk("sat_drop", 32'(drop_cnt), 32'h0000FFFF);
    chk("sat_ovf", 32'(ovf_flag), 32'h1);
    pulse_clr();
    chk("sat_clr_drop", 32'(drop_cnt), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
